// File: rtl/uart_rx_fsmd.sv
// UART receiver: 2-FF line synchroniser, mid-bit sampling FSM, LSB-first shift register,
// optional parity check and stop-bit check with a one-cycle data_valid pulse.
module uart_rx_fsmd #(
   parameter int parity_on           = 1,
   parameter int data_size           = 8,
   parameter int sampling_cntr_width = 4,
   parameter int even_parity         = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           Rx_s,
   input  logic [sampling_cntr_width-1:0] sampling_end_val,
   output logic [data_size-1:0]           Rx_data,
   output logic                           data_valid,
   output logic                           parity_err,
   output logic                           frame_err,
   output logic                           busy
);

   localparam int BCW = (data_size > 1) ? $clog2(data_size) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(data_size - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                         r_state, w_next;
   logic                           r_sync1, r_rx_q;
   logic [sampling_cntr_width-1:0] r_p_end, r_cnt, w_mid;
   logic [BCW-1:0]                 r_bit_cnt;
   logic [data_size-1:0]           r_shift, r_rx_data;
   logic                           r_par_bit, r_data_valid, r_parity_err, r_frame_err;
   logic                           w_sample, w_bit_end, w_exp_par;

   assign w_mid     = r_p_end >> 1;
   assign w_sample  = (r_cnt == w_mid);
   assign w_bit_end = (r_cnt == r_p_end);
   assign w_exp_par = (even_parity != 0) ? ^r_shift : ~^r_shift;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (!r_rx_q) w_next = START;
         // A line already high again at mid start bit was only a glitch.
         START:  if (w_sample && r_rx_q) w_next = IDLE;
                 else if (w_bit_end)      w_next = DATA;
         DATA:   if (w_bit_end && (r_bit_cnt == LAST_BIT))
                    w_next = (parity_on != 0) ? PARITY : STOP;
         PARITY: if (w_bit_end) w_next = STOP;
         STOP:   if (w_sample) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sync1      <= 1'b1;
         r_rx_q       <= 1'b1;
         r_p_end      <= '0;
         r_cnt        <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_bit    <= 1'b0;
         r_rx_data    <= '0;
         r_data_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_sync1      <= Rx_s;
         r_rx_q       <= r_sync1;
         r_state      <= w_next;
         r_data_valid <= 1'b0;

         if (r_state == IDLE || w_bit_end) r_cnt <= '0;
         else                              r_cnt <= r_cnt + 1'b1;

         if (r_state == IDLE && !r_rx_q) begin
            r_p_end   <= sampling_end_val;
            r_bit_cnt <= '0;
         end

         case (r_state)
            DATA: begin
               if (w_sample) r_shift[r_bit_cnt] <= r_rx_q;
               if (w_bit_end && (r_bit_cnt != LAST_BIT)) r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            PARITY: if (w_sample) r_par_bit <= r_rx_q;
            STOP: if (w_sample) begin
               r_rx_data    <= r_shift;
               r_frame_err  <= ~r_rx_q;
               r_parity_err <= (parity_on != 0) && (r_par_bit != w_exp_par);
               r_data_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Rx_data    = r_rx_data;
   assign data_valid = r_data_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Bench for uart_rx_fsmd: a parity-on and a parity-off receiver driven with directed and
// random frames; decoded words, flags and pulse timing are compared with a frame-level model.
module tb_uart_rx_fsmd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx0 = 1'b1, rx1 = 1'b1;
   logic [3:0] sev = 4'd15;
   logic [7:0] d0, d1;
   logic       dv0, dv1, pe0, pe1, fe0, fe1, b0, b1;

   always #5 clk = ~clk;

   uart_rx_fsmd #(.parity_on(1), .data_size(8), .sampling_cntr_width(4), .even_parity(1)) u_par (
      .clk(clk), .rst(rst), .Rx_s(rx0), .sampling_end_val(sev),
      .Rx_data(d0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0), .busy(b0));

   uart_rx_fsmd #(.parity_on(0), .data_size(8), .sampling_cntr_width(4), .even_parity(1)) u_nopar (
      .clk(clk), .rst(rst), .Rx_s(rx1), .sampling_end_val(sev),
      .Rx_data(d1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1), .busy(b1));

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      time        t;
   } rec_t;

   rec_t       got0[$], got1[$], exp0[$], exp1[$];
   int         total = 0, bad = 0;
   logic       pdv0 = 1'b0, pdv1 = 1'b0;
   logic [7:0] last0 = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Capture every valid pulse and confirm it lasts a single cycle.
   always @(negedge clk) begin
      if (dv0) begin
         check("dv0_one_cycle", pdv0, 0);
         got0.push_back('{d0, pe0, fe0, $time});
      end
      if (dv1) begin
         check("dv1_one_cycle", pdv1, 0);
         got1.push_back('{d1, pe1, fe1, $time});
      end
      pdv0 = dv0;
      pdv1 = dv1;
   end

   task automatic drive_bit(input int which, input logic val, input int n);
      if (which == 0) rx0 = val;
      else            rx1 = val;
      repeat (n) @(negedge clk);
   endtask

   // Frame model: data LSB first, optional parity bit, stop bit; a bad stop bit is held low
   // only past mid-bit so the receiver's immediate restart sees idle and rejects it.
   task automatic send(input int which, input logic [7:0] d, input logic pbit, input logic stop,
                       input int pend, input int new_sev, input int gap);
      int   p, mid, nb, g;
      rec_t e;
      p   = pend + 1;
      mid = pend / 2;
      nb  = (which == 0) ? 10 : 9;
      g   = (gap < 0) ? 2 * p + 4 : gap;
      sev = pend[3:0];
      e.d  = d;
      e.pe = (which == 0) && (pbit != ^d);
      e.fe = !stop;
      e.t  = $time + time'((2 + p * nb + mid + 1) * 10);
      if (which == 0) exp0.push_back(e);
      else            exp1.push_back(e);
      drive_bit(which, 1'b0, p);
      if (new_sev >= 0) sev = new_sev[3:0];
      check("busy_in_frame", (which == 0) ? b0 : b1, 1);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i], p);
      if (which == 0) drive_bit(which, pbit, p);
      if (stop) drive_bit(which, 1'b1, p);
      else begin
         drive_bit(which, 1'b0, mid + 2);
         drive_bit(which, 1'b1, p - mid - 2);
      end
      if (g > 0) drive_bit(which, 1'b1, g);
   endtask

   task automatic drain(input int which);
      int     n;
      rec_t   g, e;
      longint diff;
      n = 0;
      while (((which == 0) ? (got0.size() < exp0.size()) : (got1.size() < exp1.size())) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (which == 0) check("frames_seen0", got0.size(), exp0.size());
      else            check("frames_seen1", got1.size(), exp1.size());
      while ((which == 0) ? (got0.size() > 0 && exp0.size() > 0) : (got1.size() > 0 && exp1.size() > 0)) begin
         if (which == 0) begin g = got0.pop_front(); e = exp0.pop_front(); last0 = e.d; end
         else begin            g = got1.pop_front(); e = exp1.pop_front(); end
         diff = longint'(g.t) - longint'(e.t);
         check("rx_data", g.d, e.d);
         check("parity_err", g.pe, e.pe);
         check("frame_err", g.fe, e.fe);
         check("latency_window", (diff >= -10 && diff <= 10), 1);
      end
      got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      repeat (3) @(negedge clk);
      check("rst_rx_data", d0, 0);
      check("rst_busy", b0, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_valid", dv0, 0);
      check("idle_flags", {pe0, fe0, pe1, fe1}, 0);
      check("idle_busy", {b0, b1}, 0);

      // Clean frame, bad parity, bad stop, then clean again.
      send(0, 8'hA5, 1'b0, 1'b1, 15, -1, -1); drain(0);
      send(0, 8'h3C, 1'b1, 1'b1, 15, -1, -1); drain(0);
      send(0, 8'h81, 1'b0, 1'b0, 15, -1, -1); drain(0);
      send(0, 8'h55, 1'b0, 1'b1, 15, -1, -1); drain(0);

      // Short low glitch is rejected.
      drive_bit(0, 1'b0, 4);
      drive_bit(0, 1'b1, 40);
      check("glitch_no_valid", got0.size(), 0);
      check("glitch_busy", b0, 0);
      check("glitch_rx_hold", d0, last0);

      // Back-to-back frames; period change during frame 1 applies from frame 2.
      send(0, 8'h12, ^8'h12, 1'b1, 15, 7, 0);
      send(0, 8'hEF, ^8'hEF, 1'b1, 7, -1, -1);
      drain(0);
      send(0, 8'h12, ^8'h12, 1'b1, 7, -1, 0);
      send(0, 8'hEF, ^8'hEF, 1'b1, 7, -1, -1);
      drain(0);

      // Reset in the middle of data bit 4 aborts the frame.
      d   = 8'h5A;
      sev = 4'd15;
      drive_bit(0, 1'b0, 16);
      for (int i = 0; i < 4; i++) drive_bit(0, d[i], 16);
      drive_bit(0, d[4], 8);
      rst = 1'b1;
      rx0 = 1'b1;
      #1;
      check("mid_rst_outputs", {d0, dv0, pe0, fe0, b0}, 0);
      last0 = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive_bit(0, 1'b1, 40);
      check("mid_rst_no_valid", got0.size(), 0);
      send(0, 8'h5A, ^8'h5A, 1'b1, 15, -1, -1); drain(0);

      // Parity-off receiver: 9-bit frames.
      send(1, 8'hA5, 1'b0, 1'b1, 15, -1, -1); drain(1);
      send(1, 8'h81, 1'b0, 1'b0, 15, -1, -1); drain(1);
      send(1, 8'h55, 1'b0, 1'b1, 15, -1, -1); drain(1);

      // Random frames with random period, occasional parity and stop errors.
      for (int i = 0; i < 24; i++) begin
         int         which, pend;
         logic [7:0] rd;
         logic       pb, st;
         which = i % 2;
         pend  = int'($urandom_range(15, 3));
         rd    = 8'($urandom);
         pb    = (^rd) ^ ($urandom_range(3, 0) == 0);
         st    = ($urandom_range(3, 0) != 0);
         send(which, rd, pb, st, pend, -1, -1);
         drain(which);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
